// File: rtl/apb3_multi_timer.sv
// APB3 slave exposing CHANNELS independent down-counting timers with one-shot or
// periodic reload, sticky write-1-to-clear expiry status, maskable irq and tick pulse.
module apb3_multi_timer #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [31:0]           PWDATA,
    output logic                  PREADY,
    output logic [31:0]           PRDATA,
    output logic                  PSLVERROR,
    output logic [CHANNELS-1:0]   irq,
    output logic                  irq_any,
    output logic [CHANNELS-1:0]   tick
);
    localparam logic [ADDR_WIDTH-1:0] MAP_END = ADDR_WIDTH'(CHANNELS * 16);

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_LOAD   = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    logic [2:0]           ctrl_q  [CHANNELS];
    logic [2:0]           ctrl_d  [CHANNELS];
    logic [CNT_WIDTH-1:0] load_q  [CHANNELS];
    logic [CNT_WIDTH-1:0] load_d  [CHANNELS];
    logic [CNT_WIDTH-1:0] count_q [CHANNELS];
    logic [CNT_WIDTH-1:0] count_d [CHANNELS];
    logic [CHANNELS-1:0]  expired_q, expired_d;
    logic [CHANNELS-1:0]  tick_q, tick_d;
    logic [CHANNELS-1:0]  irq_en;
    logic [CHANNELS-1:0]  ch_sel;
    logic [31:0]          prdata_q, prdata_d;
    logic [31:0]          rdata;

    logic mapped;
    logic wr_en;
    logic rd_setup;
    logic unused_bits;

    assign mapped      = (PADDR < MAP_END);
    assign wr_en       = PSEL & PENABLE & PWRITE & mapped;
    assign rd_setup    = PSEL & ~PENABLE & ~PWRITE;
    assign unused_bits = ^{PADDR[1:0], PWDATA};

    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            ch_sel[i] = mapped && (PADDR[6:4] == 3'(i));
            irq_en[i] = ctrl_q[i][2];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            ctrl_d[i]    = ctrl_q[i];
            load_d[i]    = load_q[i];
            count_d[i]   = count_q[i];
            expired_d[i] = expired_q[i];
            tick_d[i]    = ctrl_q[i][0] && (count_q[i] == '0);

            if (ctrl_q[i][0]) begin
                if (!tick_d[i])
                    count_d[i] = count_q[i] - CNT_WIDTH'(1);
                else if (ctrl_q[i][1])
                    count_d[i] = load_q[i];
                else
                    ctrl_d[i][0] = 1'b0;
            end

            if (wr_en && ch_sel[i]) begin
                case (PADDR[3:2])
                    REG_CTRL: begin
                        // Writing enable=1 while running keeps the expiry-derived enable
                        // so a one-shot still stops; only a 0->1 edge reloads COUNT.
                        ctrl_d[i][2:1] = PWDATA[2:1];
                        if (!PWDATA[0]) begin
                            ctrl_d[i][0] = 1'b0;
                        end else if (!ctrl_q[i][0]) begin
                            ctrl_d[i][0] = 1'b1;
                            count_d[i]   = load_q[i];
                        end
                    end
                    REG_LOAD:   load_d[i] = PWDATA[CNT_WIDTH-1:0];
                    REG_STATUS: if (PWDATA[0]) expired_d[i] = 1'b0;
                    default: ;
                endcase
            end

            if (tick_d[i])
                expired_d[i] = 1'b1;
        end
    end

    always_comb begin
        rdata = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (ch_sel[i]) begin
                case (PADDR[3:2])
                    REG_CTRL:   rdata[2:0]           = ctrl_q[i];
                    REG_LOAD:   rdata[CNT_WIDTH-1:0] = load_q[i];
                    REG_COUNT:  rdata[CNT_WIDTH-1:0] = count_q[i];
                    REG_STATUS: rdata[0]             = expired_q[i];
                    default: ;
                endcase
            end
        end
        prdata_d = rd_setup ? rdata : prdata_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                ctrl_q[i]  <= '0;
                load_q[i]  <= '0;
                count_q[i] <= '0;
            end
            expired_q <= '0;
            tick_q    <= '0;
            prdata_q  <= '0;
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                ctrl_q[i]  <= ctrl_d[i];
                load_q[i]  <= load_d[i];
                count_q[i] <= count_d[i];
            end
            expired_q <= expired_d;
            tick_q    <= tick_d;
            prdata_q  <= prdata_d;
        end
    end

    assign PREADY    = 1'b1;
    assign PRDATA    = prdata_q;
    assign PSLVERROR = PSEL & PENABLE & ~mapped;
    assign irq       = expired_q & irq_en;
    assign irq_any   = |irq;
    assign tick      = tick_q;

endmodule
